// File: rtl/matrix_lsu_sched.sv
// rtl/matrix_lsu_sched.sv - round-robin scheduler issuing load/store matrix descriptors to one LSU
module matrix_lsu_sched #(
   parameter int ID_WIDTH   = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   // load requester (port 0)
   input  logic                ld_valid_i,
   output logic                ld_ready_o,
   input  logic [31:0]         ld_ptr_i,
   input  logic [31:0]         ld_stride_i,
   input  logic [31:0]         ld_rows_i,
   input  logic [31:0]         ld_cols_i,
   input  logic [ID_WIDTH-1:0] ld_id_i,
   // store requester (port 1)
   input  logic                st_valid_i,
   output logic                st_ready_o,
   input  logic [31:0]         st_ptr_i,
   input  logic [31:0]         st_stride_i,
   input  logic [31:0]         st_rows_i,
   input  logic [31:0]         st_cols_i,
   input  logic [ID_WIDTH-1:0] st_id_i,
   // LSU side
   output logic                lsu_start_o,
   output logic                lsu_write_o,
   output logic [31:0]         lsu_src_ptr_o,
   output logic [31:0]         lsu_stride_o,
   output logic [31:0]         lsu_rows_o,
   output logic [31:0]         lsu_cols_o,
   input  logic                lsu_busy_i,
   input  logic                lsu_terminate_i,
   // completion report
   output logic                done_o,
   output logic [ID_WIDTH-1:0] done_id_o,
   output logic                done_port_o,
   output logic                done_err_o,
   output logic                busy_o,
   output logic [31:0]         cmd_cnt_o
);

   localparam logic [31:0] ALIGN_MASK = 32'(DATA_WIDTH / 8) - 32'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic                last_grant_q;
   logic                port_q;
   logic                err_q;
   logic [31:0]         ptr_q, stride_q, rows_q, cols_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [31:0]         cnt_q;

   logic                gnt_port;
   logic                accept;
   logic [31:0]         sel_ptr, sel_stride, sel_rows, sel_cols;
   logic [ID_WIDTH-1:0] sel_id;
   logic                misaligned;
   logic                zero_size;

   // On a tie the port that did not win last time is served.
   always_comb begin
      gnt_port = 1'b0;
      if (ld_valid_i && st_valid_i) begin
         gnt_port = ~last_grant_q;
      end else if (st_valid_i) begin
         gnt_port = 1'b1;
      end
   end

   assign accept     = (state_q == IDLE) && (ld_valid_i || st_valid_i);
   assign ld_ready_o = accept && !gnt_port;
   assign st_ready_o = accept && gnt_port;

   assign sel_ptr    = gnt_port ? st_ptr_i    : ld_ptr_i;
   assign sel_stride = gnt_port ? st_stride_i : ld_stride_i;
   assign sel_rows   = gnt_port ? st_rows_i   : ld_rows_i;
   assign sel_cols   = gnt_port ? st_cols_i   : ld_cols_i;
   assign sel_id     = gnt_port ? st_id_i     : ld_id_i;

   assign misaligned = |(sel_ptr & ALIGN_MASK);
   assign zero_size  = (sel_rows == 32'd0) || (sel_cols == 32'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lsu_start_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               // Bad or empty descriptors never reach the LSU.
               if (misaligned || zero_size) begin
                  state_d = DONE;
               end else begin
                  state_d = START;
               end
            end
         end
         START: begin
            if (!lsu_busy_i) begin
               lsu_start_o = 1'b1;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (lsu_terminate_i) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         err_q        <= 1'b0;
         ptr_q        <= '0;
         stride_q     <= '0;
         rows_q       <= '0;
         cols_q       <= '0;
         id_q         <= '0;
         cnt_q        <= '0;
      end else begin
         if (accept) begin
            last_grant_q <= gnt_port;
            port_q       <= gnt_port;
            err_q        <= misaligned;
            ptr_q        <= sel_ptr;
            stride_q     <= sel_stride;
            rows_q       <= sel_rows;
            cols_q       <= sel_cols;
            id_q         <= sel_id;
         end
         if (state_q == DONE) begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

   assign lsu_write_o   = port_q;
   assign lsu_src_ptr_o = ptr_q;
   assign lsu_stride_o  = stride_q;
   assign lsu_rows_o    = rows_q;
   assign lsu_cols_o    = cols_q;

   assign done_o      = (state_q == DONE);
   assign done_id_o   = id_q;
   assign done_port_o = port_q;
   assign done_err_o  = err_q;
   assign busy_o      = (state_q != IDLE);
   assign cmd_cnt_o   = cnt_q;

endmodule
